i_mem_fetch_q: RTL and testbench

I_MEM_FETCH_Q -- requirements
Module: i_mem_fetch_q

---
 rtl/big_core_pkg.sv | 8 +
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/mem.sv | 53 +++++
 rtl/i_mem_fetch_q.sv | 104 ++++++++++
 tb/tb_i_mem_fetch_q.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/big_core_pkg.sv
// Shared configuration defaults for the big core instruction-side blocks.
package big_core_pkg;

  localparam int I_MEM_ADRS_MSB_DFLT = 15;
  localparam int FQ_DEPTH_DFLT       = 4;
  localparam int WORD_WIDTH_DFLT     = 32;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: power-of-two FIFO whose head output holds the last popped entry when empty.
// Push while full is taken only together with a pop; flush empties the queue.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             full, pop, push;

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = valid_o & ready_i & ~flush_i;
  assign push    = push_i & ~flush_i & (~full | pop);

  always_comb begin
    // NOTE: defaults first so no path leaves a next-state unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        last_d   = store_q[rd_ptr_q];
      end
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) store_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = valid_o ? store_q[rd_ptr_q] : last_q;
  assign count_o = count_q;

endmodule

// File: rtl/mem.sv
// True dual-port word memory: port a is read-only, port b reads/writes with byte enables.
// Both ports return read data one cycle after the request.
module mem #(
  parameter int ADRS_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_rd_en_i,
  input  logic [ADRS_WIDTH-1:0]   a_adrs_i,
  output logic [DATA_WIDTH-1:0]   a_rd_data_o,
  input  logic                    b_wr_en_i,
  input  logic                    b_rd_en_i,
  input  logic [ADRS_WIDTH-1:0]   b_adrs_i,
  input  logic [DATA_WIDTH-1:0]   b_wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] b_byte_en_i,
  output logic [DATA_WIDTH-1:0]   b_rd_data_o
);

  localparam int DEPTH  = 1 << ADRS_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] ram_q [DEPTH];
  logic [DATA_WIDTH-1:0] a_rd_data_q;
  logic [DATA_WIDTH-1:0] b_rd_data_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents survive Rst.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (b_wr_en_i) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (b_byte_en_i[i]) ram_q[b_adrs_i][8*i +: 8] <= b_wr_data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (a_rd_en_i) a_rd_data_q <= ram_q[a_adrs_i];
  end

  // A port b write wins over a same-cycle port b read; the read data is left untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_rd_data_q <= '0;
    end else if (b_rd_en_i && !b_wr_en_i) begin
      b_rd_data_q <= ram_q[b_adrs_i];
    end
  end

  assign a_rd_data_o = a_rd_data_q;
  assign b_rd_data_o = b_rd_data_q;

endmodule

// File: rtl/i_mem_fetch_q.sv
// Instruction memory with a core fetch queue on port a and a fabric access port on port b.
// A fetch accepted in Q100H lands in the queue one cycle later and is visible at the head the cycle after.
module i_mem_fetch_q
  import big_core_pkg::*;
#(
  parameter int I_MEM_ADRS_MSB = I_MEM_ADRS_MSB_DFLT,
  parameter int FQ_DEPTH       = FQ_DEPTH_DFLT,
  parameter int WORD_WIDTH     = WORD_WIDTH_DFLT
) (
  input  logic                    Clock,
  input  logic                    Rst,
  input  logic [31:0]             PcQ100H,
  input  logic                    PcValidQ100H,
  output logic                    FetchReadyQ100H,
  input  logic                    FlushQ100H,
  output logic [WORD_WIDTH-1:0]   InstructionQ101H,
  output logic [31:0]             InstPcQ101H,
  output logic                    InstValidQ101H,
  input  logic                    ReadyQ101H,
  input  logic                    FabWrEn,
  input  logic                    FabRdEn,
  input  logic [31:0]             FabAdrs,
  input  logic [WORD_WIDTH-1:0]   FabWrData,
  input  logic [WORD_WIDTH/8-1:0] FabByteEn,
  output logic [WORD_WIDTH-1:0]   FabRdData,
  output logic                    FabRdValid
);

  localparam int AW = I_MEM_ADRS_MSB - 1;
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int QW = WORD_WIDTH + 32;

  logic                  accept, wr_hazard;
  logic                  inflight_q, inflight_d;
  logic [31:0]           pc_inflight_q, pc_inflight_d;
  logic                  fab_rd_valid_q, fab_rd_valid_d;
  logic [CW-1:0]         fifo_count, occupancy;
  logic [WORD_WIDTH-1:0] fetch_rd_data;
  logic [QW-1:0]         head_data;
  logic                  unused_adrs_bits;

  assign unused_adrs_bits = ^{FabAdrs[31:I_MEM_ADRS_MSB+1], FabAdrs[1:0]};

  // A fabric write to the fetched word stalls the fetch, so port a never reads a word mid-write.
  assign wr_hazard       = FabWrEn & (FabAdrs[I_MEM_ADRS_MSB:2] == PcQ100H[I_MEM_ADRS_MSB:2]);
  assign occupancy       = fifo_count + CW'(inflight_q);
  assign FetchReadyQ100H = (occupancy < CW'(FQ_DEPTH)) & ~FlushQ100H & ~wr_hazard;
  assign accept          = PcValidQ100H & FetchReadyQ100H;

  always_comb begin
    inflight_d     = accept;
    pc_inflight_d  = accept ? PcQ100H : pc_inflight_q;
    fab_rd_valid_d = FabRdEn & ~FabWrEn;
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      inflight_q     <= 1'b0;
      pc_inflight_q  <= '0;
      fab_rd_valid_q <= 1'b0;
    end else begin
      inflight_q     <= inflight_d;
      pc_inflight_q  <= pc_inflight_d;
      fab_rd_valid_q <= fab_rd_valid_d;
    end
  end

  mem #(
    .ADRS_WIDTH (AW),
    .DATA_WIDTH (WORD_WIDTH)
  ) u_mem (
    .clk         (Clock),
    .rst         (Rst),
    .a_rd_en_i   (accept),
    .a_adrs_i    (PcQ100H[I_MEM_ADRS_MSB:2]),
    .a_rd_data_o (fetch_rd_data),
    .b_wr_en_i   (FabWrEn),
    .b_rd_en_i   (FabRdEn),
    .b_adrs_i    (FabAdrs[I_MEM_ADRS_MSB:2]),
    .b_wr_data_i (FabWrData),
    .b_byte_en_i (FabByteEn),
    .b_rd_data_o (FabRdData)
  );

  // The in-flight word is pushed the cycle after accept; a flush in that cycle drops it.
  fetch_fifo #(
    .WIDTH (QW),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_fifo (
    .clk     (Clock),
    .rst     (Rst),
    .flush_i (FlushQ100H),
    .push_i  (inflight_q),
    .data_i  ({fetch_rd_data, pc_inflight_q}),
    .ready_i (ReadyQ101H),
    .valid_o (InstValidQ101H),
    .data_o  (head_data),
    .count_o (fifo_count)
  );

  assign {InstructionQ101H, InstPcQ101H} = head_data;
  assign FabRdValid = fab_rd_valid_q;

endmodule

// File: tb/tb_i_mem_fetch_q.sv
// Scoreboard bench for i_mem_fetch_q: a negedge monitor predicts ready/valid/head and fabric reads
// from a memory model and an expected-fetch queue; directed phases cover the key scenarios.
module tb_i_mem_fetch_q;

  localparam int MSB   = 15;
  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] PcQ100H = '0;
  logic        PcValidQ100H = 1'b0;
  logic        FetchReadyQ100H;
  logic        FlushQ100H = 1'b0;
  logic [31:0] InstructionQ101H;
  logic [31:0] InstPcQ101H;
  logic        InstValidQ101H;
  logic        ReadyQ101H = 1'b0;
  logic        FabWrEn = 1'b0;
  logic        FabRdEn = 1'b0;
  logic [31:0] FabAdrs = '0;
  logic [31:0] FabWrData = '0;
  logic [3:0]  FabByteEn = '0;
  logic [31:0] FabRdData;
  logic        FabRdValid;

  i_mem_fetch_q #(
    .I_MEM_ADRS_MSB (MSB),
    .FQ_DEPTH       (DEPTH),
    .WORD_WIDTH     (32)
  ) dut (
    .Clock            (Clock),
    .Rst              (Rst),
    .PcQ100H          (PcQ100H),
    .PcValidQ100H     (PcValidQ100H),
    .FetchReadyQ100H  (FetchReadyQ100H),
    .FlushQ100H       (FlushQ100H),
    .InstructionQ101H (InstructionQ101H),
    .InstPcQ101H      (InstPcQ101H),
    .InstValidQ101H   (InstValidQ101H),
    .ReadyQ101H       (ReadyQ101H),
    .FabWrEn          (FabWrEn),
    .FabRdEn          (FabRdEn),
    .FabAdrs          (FabAdrs),
    .FabWrData        (FabWrData),
    .FabByteEn        (FabByteEn),
    .FabRdData        (FabRdData),
    .FabRdValid       (FabRdValid)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Memory model, keyed by word index.
  logic [31:0] mdl [int];

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    int k;
    k = int'(a[MSB:2]);
    return mdl.exists(k) ? mdl[k] : 32'h0;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          t;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_instr = '0;
  logic [31:0] last_pc = '0;
  logic        last_accept = 1'b0;
  logic        fab_pend = 1'b0;
  logic [31:0] fab_exp = '0;
  int          n_pops = 0;

  always @(negedge Clock) begin
    logic exp_ready, exp_valid;
    exp_t e;
    int k;
    logic [31:0] w;
    if (Rst) begin
      sb.delete();
      last_instr  = '0;
      last_pc     = '0;
      last_accept = 1'b0;
      fab_pend    = 1'b0;
    end else begin
      exp_ready = (sb.size() < DEPTH) && !FlushQ100H &&
                  !(FabWrEn && (FabAdrs[MSB:2] == PcQ100H[MSB:2]));
      check("fetch_ready", FetchReadyQ100H, exp_ready);
      exp_valid = (sb.size() > 0) && ((cyc - sb[0].t) >= 2);
      check("inst_valid", InstValidQ101H, exp_valid);
      if (exp_valid) begin
        check("head_instr", InstructionQ101H, sb[0].instr);
        check("head_pc", InstPcQ101H, sb[0].pc);
      end else begin
        check("hold_instr", InstructionQ101H, last_instr);
        check("hold_pc", InstPcQ101H, last_pc);
      end
      check("fab_rd_valid", FabRdValid, fab_pend);
      if (fab_pend) check("fab_rd_data", FabRdData, fab_exp);

      if (FlushQ100H) begin
        sb.delete();
      end else if (InstValidQ101H && ReadyQ101H && exp_valid) begin
        last_instr = sb[0].instr;
        last_pc    = sb[0].pc;
        void'(sb.pop_front());
        n_pops++;
      end
      last_accept = PcValidQ100H && FetchReadyQ100H;
      if (last_accept && !FlushQ100H) begin
        e.pc    = PcQ100H;
        e.instr = mdl_rd(PcQ100H);
        e.t     = cyc;
        sb.push_back(e);
      end
      fab_pend = FabRdEn && !FabWrEn;
      fab_exp  = mdl_rd(FabAdrs);
      if (FabWrEn) begin
        k = int'(FabAdrs[MSB:2]);
        w = mdl_rd(FabAdrs);
        for (int i = 0; i < 4; i++) if (FabByteEn[i]) w[8*i +: 8] = FabWrData[8*i +: 8];
        mdl[k] = w;
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic fab_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    FabWrEn = 1'b1; FabAdrs = a; FabWrData = d; FabByteEn = be;
    step();
    FabWrEn = 1'b0;
  endtask

  // Issue n fetches from start, stride 4, advancing only on acceptance.
  task automatic fetch_seq(input logic [31:0] start, input int n, output int cycles);
    logic [31:0] pc;
    int acc;
    pc = start; acc = 0; cycles = 0;
    PcValidQ100H = 1'b1; PcQ100H = pc;
    while (acc < n && cycles < 200) begin
      step();
      cycles++;
      if (last_accept) begin
        acc++;
        pc = pc + 32'd4;
        PcQ100H = pc;
      end
    end
    PcValidQ100H = 1'b0;
    check("fetch_seq_accepts", acc, n);
  endtask

  // Request fetches continuously for a fixed number of cycles.
  task automatic fetch_for(input logic [31:0] start, input int ncyc, output int acc);
    logic [31:0] pc;
    pc = start; acc = 0;
    PcValidQ100H = 1'b1; PcQ100H = pc;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (last_accept) begin
        acc++;
        pc = pc + 32'd4;
        PcQ100H = pc;
      end
    end
    PcValidQ100H = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    ReadyQ101H = 1'b1;
    PcValidQ100H = 1'b0;
    while (sb.size() != 0 && k < 200) begin
      step();
      k++;
    end
    check("drain_empty", sb.size(), 0);
    step();
  endtask

  initial begin
    int cycles, acc, pops0;

    Rst = 1'b1;
    repeat (3) step();
    Rst = 1'b0;
    check("rst_valid", InstValidQ101H, 0);
    check("rst_instr", InstructionQ101H, 0);
    check("rst_pc", InstPcQ101H, 0);
    check("rst_fab_valid", FabRdValid, 0);
    check("rst_fab_data", FabRdData, 0);

    for (int a = 0; a < 16; a += 4) fab_write(32'(a), 32'h13, 4'hF);
    for (int a = 16; a < 128; a += 4) fab_write(32'(a), 32'h1000_0000 | 32'(a), 4'hF);
    fab_write(32'h10, 32'hAABB_CCDD, 4'b0101);

    // In-order back-to-back fetch with the core always ready.
    ReadyQ101H = 1'b1;
    fetch_seq(32'h0, 4, cycles);
    check("b2b_cycles", cycles, 4);
    drain();
    fetch_seq(32'h10, 1, cycles);
    drain();

    // Stalled core: the queue fills to its depth, then resumes as slots free.
    ReadyQ101H = 1'b0;
    fetch_for(32'h20, 8, acc);
    check("full_accepts", acc, DEPTH);
    check("full_not_ready", FetchReadyQ100H, 0);
    ReadyQ101H = 1'b1;
    fetch_seq(32'h30, 4, cycles);
    drain();

    // Flush with three queued and one in flight.
    ReadyQ101H = 1'b0;
    fetch_for(32'h50, 4, acc);
    check("pre_flush_accepts", acc, 4);
    check("pre_flush_valid", InstValidQ101H, 1);
    FlushQ100H = 1'b1;
    step();
    FlushQ100H = 1'b0;
    check("flush_valid", InstValidQ101H, 0);
    pops0 = n_pops;
    ReadyQ101H = 1'b1;
    fetch_seq(32'h40, 1, cycles);
    drain();
    check("flush_pops", n_pops - pops0, 1);

    // Fabric write to the word being fetched stalls that fetch for one cycle.
    FabWrEn = 1'b1; FabAdrs = 32'h8; FabWrData = 32'hDEAD_BEEF; FabByteEn = 4'hF;
    PcValidQ100H = 1'b1; PcQ100H = 32'h8;
    step();
    FabWrEn = 1'b0;
    check("hazard_stall", last_accept, 0);
    fetch_seq(32'h8, 1, cycles);
    check("hazard_retry_cycles", cycles, 1);
    drain();

    // Fabric read alongside a core fetch, then read+write in the same cycle.
    FabRdEn = 1'b1; FabAdrs = 32'h4;
    PcValidQ100H = 1'b1; PcQ100H = 32'h14;
    step();
    FabRdEn = 1'b0; PcValidQ100H = 1'b0;
    check("rd_concurrent_accept", last_accept, 1);
    check("fab_rd_valid_dir", FabRdValid, 1);
    check("fab_rd_data_dir", FabRdData, 32'h13);
    FabRdEn = 1'b1; FabWrEn = 1'b1; FabAdrs = 32'h70; FabWrData = 32'h0BAD_F00D; FabByteEn = 4'hF;
    step();
    FabRdEn = 1'b0; FabWrEn = 1'b0;
    check("rdwr_valid", FabRdValid, 0);
    FabRdEn = 1'b1; FabAdrs = 32'h70;
    step();
    FabRdEn = 1'b0;
    drain();

    // Reset while the queue is full; memory contents must survive.
    ReadyQ101H = 1'b0;
    fetch_for(32'h60, 6, acc);
    check("pre_rst_accepts", acc, DEPTH);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("mid_rst_valid", InstValidQ101H, 0);
    check("mid_rst_instr", InstructionQ101H, 0);
    check("mid_rst_pc", InstPcQ101H, 0);
    check("mid_rst_fab_valid", FabRdValid, 0);
    check("mid_rst_fab_data", FabRdData, 0);
    check("mid_rst_ready", FetchReadyQ100H, 1);
    ReadyQ101H = 1'b1;
    fetch_seq(32'h0, 4, cycles);
    fetch_seq(32'h6C, 2, cycles);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
